mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It consumes the EX/MEM outputs, owns the data memory, and resolves branch/jump redirection. It passes writeback controls downstream. A configurable wait-state FSM models multi-cycle data memory and raises a pipeline stall to the hazard unit.

## Interface
Parameters:
- DEPTH, 256: data memory depth in 32-bit words; power of two.
- MEM_LATENCY, 0: wait-state cycles per load/store; 0 = single-cycle access.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- resultIn  in  32  ALU result / byte address.
- PCIn  in  32  branch/jump target.
- OR_PCIn  in  32  original PC+4, used as the jal link value.
- RD2In  in  32  store data.
- WNIn  in  5  destination register.
- jumpIn, regWriteIn, memToRegIn, memReadIn, memWriteIn, branchIn, zeroIn, jalIn  in  1 each  control from EX/MEM.
- readDataOut  out  32  load data.
- resultOut  out  32  resultIn passthrough.
- OR_PCOut  out  32  OR_PCIn passthrough.
- WNOut  out  5  WNIn passthrough.
- regWriteOut, memToRegOut, jalOut  out  1 each  writeback controls, gated as described under Operation.
- redirectOut  out  1  fetch must load redirectTarget.
- redirectTarget  out  32  PCIn passthrough.
- stallOut  out  1  hazard unit must hold PC, IF/ID, ID/EX and EX/MEM. Those registers hold, and the EX/MEM inputs stay stable, while stallOut=1.

## Operation
- Word address is resultIn[log2(DEPTH)+1:2].
  - Bits [1:0] are ignored; no misalignment trap.
  - Higher bits are ignored, so addresses wrap modulo DEPTH words.
- access = memReadIn | memWriteIn. If both are set, a write is performed and readDataOut still shows the pre-write word.
- Branch resolution:
  - take = branchIn & zeroIn.
  - redirectOut = (take | jumpIn) & ~stallOut & ~rst.
- Writeback gating:
  - regWriteOut = regWriteIn & ~stallOut.
  - jalOut = jalIn & ~stallOut.
  - memToRegOut = memToRegIn.
  - Stalled cycles present a bubble to MEM/WB.
- MEM_LATENCY=0:
  - No FSM activity; stallOut is constantly 0.
  - Read is combinational from the array.
  - Write commits at the posedge ending the cycle in which memWriteIn=1.
- MEM_LATENCY=N>0: FSM with states IDLE and WAIT, plus counter cnt of width clog2(N+1).
  - IDLE, access=0: stallOut=0; stay in IDLE.
  - IDLE, access=1: stallOut=1; cnt<=N-1; go to WAIT. No write yet.
  - WAIT, cnt!=0: stallOut=1; cnt<=cnt-1.
  - WAIT, cnt==0: stallOut=0. This is the completion cycle: read data is valid combinationally and a write commits at the ending posedge. Go to IDLE.
  - Back-to-back accesses: the next instruction enters in IDLE and restarts the sequence. There is no pipelining of accesses.
- Reset:
  - FSM goes to IDLE and cnt to 0.
  - An in-flight store is dropped and not committed.
  - Memory contents are retained and are not initialised by rst.

## Timing
- Reset values while rst=1: stallOut=0, redirectOut=0, FSM=IDLE. Passthrough outputs follow inputs, which are zero from the EX/MEM reset.
- Load latency: readDataOut is valid in the access cycle (N=0) or in the completion cycle (N>0). MEM/WB captures it at that cycle's posedge.
- Stall duration: exactly N cycles per load/store, so each access occupies N+1 cycles.
- Redirect:
  - Combinational in the cycle the branch/jump sits in MEM.
  - Never asserted during a stalled cycle.
  - A branch or jump carries no access, so it never stalls.
- Store-to-load: a load in the cycle immediately after a store commit to the same word returns the new data.
- rst asserted in WAIT: stallOut drops in the same cycle, and the next cycle is IDLE.

## Test plan
- N=0: store 0xDEADBEEF to address 0x10, then load 0x10 -> readDataOut=0xDEADBEEF; stallOut never high.
- N=0: branchIn=1, zeroIn=1, PCIn=0x40 -> redirectOut=1, redirectTarget=0x40. With zeroIn=0 -> redirectOut=0. With jumpIn=1 -> redirectOut=1.
- N=3: load from 0x8 -> stallOut=1 for 3 cycles with regWriteOut=0; 4th cycle stallOut=0, regWriteOut=1, correct data.
- N=2: store 0x1234 to 0x20 with rst pulsed during the second stall cycle -> FSM back in IDLE; a subsequent N=2 load of 0x20 returns the old value.
- DEPTH=256: store 0x55 to byte address 0x400, then load address 0x0 -> 0x55 (wrap). Load address 0x403 -> same word as 0x400.
- jalIn=1, OR_PCIn=0x2C, WNIn=31 -> jalOut=1, OR_PCOut=0x2C, WNOut=31, redirectOut=jumpIn.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: owns the data memory, resolves branch/jump redirection and
// raises a pipeline stall while a multi-cycle load/store is in progress.
module mem_stage #(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] resultIn,
  input  logic [31:0] PCIn,
  input  logic [31:0] OR_PCIn,
  input  logic [31:0] RD2In,
  input  logic [4:0]  WNIn,
  input  logic        jumpIn,
  input  logic        regWriteIn,
  input  logic        memToRegIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  input  logic        branchIn,
  input  logic        zeroIn,
  input  logic        jalIn,
  output logic [31:0] readDataOut,
  output logic [31:0] resultOut,
  output logic [31:0] OR_PCOut,
  output logic [4:0]  WNOut,
  output logic        regWriteOut,
  output logic        memToRegOut,
  output logic        jalOut,
  output logic        redirectOut,
  output logic [31:0] redirectTarget,
  output logic        stallOut
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] addr;
  logic          access;
  logic          stall;
  logic          complete;
  logic          we;
  logic          take;
  logic [31:0]   mem_q [DEPTH];
  logic          unused_addr_bits;

  // Word-addressed, wrapping modulo DEPTH; byte-offset and high bits are dropped.
  assign addr             = resultIn[AW+1:2];
  assign unused_addr_bits = ^{resultIn[31:AW+2], resultIn[1:0]};
  assign access           = memReadIn | memWriteIn;

  generate
    if (MEM_LATENCY == 0) begin : g_single
      logic unused_access;
      assign unused_access = access;
      assign stall         = 1'b0;
      assign complete      = 1'b1;
    end else begin : g_wait
      localparam int CW = $clog2(MEM_LATENCY + 1);
      typedef enum logic {S_IDLE, S_WAIT} state_t;

      state_t        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          S_IDLE: begin
            if (access) begin
              state_d = S_WAIT;
              cnt_d   = CW'(MEM_LATENCY - 1);
            end
          end
          S_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            else             state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase
      end

      // Completion is the WAIT cycle with an exhausted counter; rst kills it at once.
      always_comb begin
        stall    = 1'b0;
        complete = 1'b0;
        case (state_q)
          S_IDLE:  stall = access & ~rst;
          S_WAIT: begin
            stall    = (cnt_q != '0) & ~rst;
            complete = (cnt_q == '0) & ~rst;
          end
          default: begin
            stall    = 1'b0;
            complete = 1'b0;
          end
        endcase
      end
    end
  endgenerate

  assign we = memWriteIn & complete & ~rst;

  // Array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= RD2In;
  end

  assign readDataOut    = mem_q[addr];
  assign take           = branchIn & zeroIn;
  assign stallOut       = stall;
  assign redirectOut    = (take | jumpIn) & ~stall & ~rst;
  assign redirectTarget = PCIn;

  // Stalled cycles become bubbles in MEM/WB.
  assign regWriteOut = regWriteIn & ~stall;
  assign jalOut      = jalIn & ~stall;
  assign memToRegOut = memToRegIn;
  assign resultOut   = resultIn;
  assign OR_PCOut    = OR_PCIn;
  assign WNOut       = WNIn;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances (latency 0, 2, 3) driven by shared inputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] resultIn, PCIn, OR_PCIn, RD2In;
  logic [4:0]  WNIn;
  logic        jumpIn, regWriteIn, memToRegIn, memReadIn, memWriteIn, branchIn, zeroIn, jalIn;

  // Index 0: MEM_LATENCY=0, 1: MEM_LATENCY=2, 2: MEM_LATENCY=3
  logic [31:0] rd [3];
  logic [31:0] res [3];
  logic [31:0] orpc [3];
  logic [31:0] tgt [3];
  logic [4:0]  wn [3];
  logic        rw [3];
  logic        m2r [3];
  logic        jal [3];
  logic        redir [3];
  logic        stl [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .MEM_LATENCY(0)) u_n0 (
    .clk(clk), .rst(rst), .resultIn(resultIn), .PCIn(PCIn), .OR_PCIn(OR_PCIn), .RD2In(RD2In),
    .WNIn(WNIn), .jumpIn(jumpIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .branchIn(branchIn), .zeroIn(zeroIn),
    .jalIn(jalIn), .readDataOut(rd[0]), .resultOut(res[0]), .OR_PCOut(orpc[0]), .WNOut(wn[0]),
    .regWriteOut(rw[0]), .memToRegOut(m2r[0]), .jalOut(jal[0]), .redirectOut(redir[0]),
    .redirectTarget(tgt[0]), .stallOut(stl[0]));

  mem_stage #(.DEPTH(256), .MEM_LATENCY(2)) u_n2 (
    .clk(clk), .rst(rst), .resultIn(resultIn), .PCIn(PCIn), .OR_PCIn(OR_PCIn), .RD2In(RD2In),
    .WNIn(WNIn), .jumpIn(jumpIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .branchIn(branchIn), .zeroIn(zeroIn),
    .jalIn(jalIn), .readDataOut(rd[1]), .resultOut(res[1]), .OR_PCOut(orpc[1]), .WNOut(wn[1]),
    .regWriteOut(rw[1]), .memToRegOut(m2r[1]), .jalOut(jal[1]), .redirectOut(redir[1]),
    .redirectTarget(tgt[1]), .stallOut(stl[1]));

  mem_stage #(.DEPTH(256), .MEM_LATENCY(3)) u_n3 (
    .clk(clk), .rst(rst), .resultIn(resultIn), .PCIn(PCIn), .OR_PCIn(OR_PCIn), .RD2In(RD2In),
    .WNIn(WNIn), .jumpIn(jumpIn), .regWriteIn(regWriteIn), .memToRegIn(memToRegIn),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .branchIn(branchIn), .zeroIn(zeroIn),
    .jalIn(jalIn), .readDataOut(rd[2]), .resultOut(res[2]), .OR_PCOut(orpc[2]), .WNOut(wn[2]),
    .regWriteOut(rw[2]), .memToRegOut(m2r[2]), .jalOut(jal[2]), .redirectOut(redir[2]),
    .redirectTarget(tgt[2]), .stallOut(stl[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    resultIn = '0; PCIn = '0; OR_PCIn = '0; RD2In = '0; WNIn = '0;
    jumpIn = 0; regWriteIn = 0; memToRegIn = 0; memReadIn = 0; memWriteIn = 0;
    branchIn = 0; zeroIn = 0; jalIn = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    jumpIn = 1'b1;
    @(negedge clk);
    chk("rst_stall_n3", 32'(stl[2]), 32'd0);
    chk("rst_stall_n2", 32'(stl[1]), 32'd0);
    chk("rst_redir_n0", 32'(redir[0]), 32'd0);
    chk("rst_resout", res[0], 32'd0);
    tick();
    rst = 1'b0;
    jumpIn = 1'b0;

    // Latency 0: store then load
    memWriteIn = 1; resultIn = 32'h10; RD2In = 32'hDEADBEEF;
    @(negedge clk);
    chk("n0_store_stall", 32'(stl[0]), 32'd0);
    tick();
    memWriteIn = 0; memReadIn = 1; regWriteIn = 1; memToRegIn = 1; RD2In = 32'h0;
    @(negedge clk);
    chk("n0_load_data", rd[0], 32'hDEADBEEF);
    chk("n0_load_rw", 32'(rw[0]), 32'd1);
    chk("n0_load_m2r", 32'(m2r[0]), 32'd1);
    chk("n0_load_stall", 32'(stl[0]), 32'd0);

    // Branch / jump redirect
    tick();
    idle_inputs();
    branchIn = 1; zeroIn = 1; PCIn = 32'h40;
    @(negedge clk);
    chk("br_taken", 32'(redir[0]), 32'd1);
    chk("br_target", tgt[0], 32'h40);
    zeroIn = 0;
    #1;
    chk("br_not_taken", 32'(redir[0]), 32'd0);
    jumpIn = 1;
    #1;
    chk("jump_redir", 32'(redir[0]), 32'd1);

    // Address wrap and ignored byte offset
    tick();
    idle_inputs();
    memWriteIn = 1; resultIn = 32'h400; RD2In = 32'h55;
    tick();
    memWriteIn = 0; memReadIn = 1; resultIn = 32'h0; RD2In = 32'h0;
    @(negedge clk);
    chk("wrap_load0", rd[0], 32'h55);
    resultIn = 32'h403;
    #1;
    chk("offset_load403", rd[0], 32'h55);
    chk("resout_pass", res[0], 32'h403);

    // jal writeback controls
    tick();
    idle_inputs();
    jalIn = 1; OR_PCIn = 32'h2C; WNIn = 5'd31; jumpIn = 1; regWriteIn = 1; PCIn = 32'h80;
    @(negedge clk);
    chk("jal_out", 32'(jal[0]), 32'd1);
    chk("jal_orpc", orpc[0], 32'h2C);
    chk("jal_wn", 32'(wn[0]), 32'd31);
    chk("jal_redir", 32'(redir[0]), 32'd1);
    chk("jal_target", tgt[0], 32'h80);

    // Latency 3: store to 0x8, then load it back
    tick();
    do_reset();
    memWriteIn = 1; resultIn = 32'h8; RD2In = 32'hCAFEF00D;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("n3_st_stall_c%0d", c), 32'(stl[2]), (c < 3) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs();
    memReadIn = 1; regWriteIn = 1; memToRegIn = 1; resultIn = 32'h8; jalIn = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("n3_ld_stall_c%0d", c), 32'(stl[2]), (c < 3) ? 32'd1 : 32'd0);
      chk($sformatf("n3_ld_rw_c%0d", c), 32'(rw[2]), (c < 3) ? 32'd0 : 32'd1);
      chk($sformatf("n3_ld_jal_c%0d", c), 32'(jal[2]), (c < 3) ? 32'd0 : 32'd1);
      if (c == 3) chk("n3_ld_data", rd[2], 32'hCAFEF00D);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    chk("n3_idle_after", 32'(stl[2]), 32'd0);

    // Latency 2: known store, aborted store, then load returns the old value
    tick();
    do_reset();
    memWriteIn = 1; resultIn = 32'h20; RD2In = 32'hAAAA5555;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("n2_st_stall_c%0d", c), 32'(stl[1]), (c < 2) ? 32'd1 : 32'd0);
      tick();
    end
    RD2In = 32'h1234;
    @(negedge clk);
    chk("n2_abort_stall1", 32'(stl[1]), 32'd1);
    tick();
    jumpIn = 1;
    @(negedge clk);
    chk("n2_abort_stall2", 32'(stl[1]), 32'd1);
    chk("n2_redir_stalled", 32'(redir[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("n2_rst_drops_stall", 32'(stl[1]), 32'd0);
    chk("n2_rst_redir", 32'(redir[1]), 32'd0);
    tick();
    rst = 1'b0;
    idle_inputs();
    memReadIn = 1; regWriteIn = 1; resultIn = 32'h20;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("n2_ld_stall_c%0d", c), 32'(stl[1]), (c < 2) ? 32'd1 : 32'd0);
      if (c == 2) chk("n2_ld_old_data", rd[1], 32'hAAAA5555);
      tick();
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
